riscv_execute_mc: RTL and testbench



---
 rtl/riscv_execute_mc.sv | 213 +++++++++++++++++++++
 tb/tb_riscv_execute_mc.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_execute_mc.sv
// Multi-cycle RV32/64 execute unit: integer ALU plus M-extension with valid/ready on both sides.
// Define RISCV_EXEC_FASTMUL_EN to replace the iterative multiplier with a single-cycle one.
module riscv_execute_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [4:0]      op_sel_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] ex_res_o
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg, op_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [XLEN-1:0]   res_reg, res_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [2*XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0]   mplier_reg, mplier_next;
  logic              msb_neg_reg, msb_neg_next;
  logic [XLEN-1:0]   rem_reg, rem_next;
  logic [XLEN-1:0]   quo_reg, quo_next;
  logic [XLEN-1:0]   dvsr_reg, dvsr_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;

  function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic [3:0] op);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (op)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a << sh;
      4'd3:    alu_f = a >> sh;
      4'd4:    alu_f = $signed(a) >>> sh;
      4'd5:    alu_f = a | b;
      4'd6:    alu_f = a & b;
      4'd7:    alu_f = a ^ b;
      4'd8:    alu_f = {{(XLEN-1){1'b0}}, a == b};
      4'd9:    alu_f = {{(XLEN-1){1'b0}}, a < b};
      4'd10:   alu_f = {{(XLEN-1){1'b0}}, a >= b};
      4'd11:   alu_f = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd12:   alu_f = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
      default: alu_f = '0;
    endcase
  endfunction

  logic            accept, is_m, is_div, a_signed, b_signed, div_signed, div_zero, div_ovf;
  logic [2:0]      mop;
  logic [2*XLEN-1:0] a_ext, pp, mul_sum;
  logic [XLEN-1:0] a_mag, b_mag, diff, rem_step, quo_step, q_fix, r_fix;
  logic [XLEN:0]   r_shift;
  logic            ge;

  assign ready_o    = (state_reg == IDLE) | ((state_reg == DONE) & ready_i);
  assign accept     = valid_i & ready_o & ~kill_i;
  assign valid_o    = (state_reg == DONE);
  assign ex_res_o   = res_reg;

  assign is_m       = op_sel_i[4];
  assign mop        = op_sel_i[2:0];
  assign is_div     = mop[2];
  assign a_signed   = (mop == 3'd1) | (mop == 3'd2);
  assign b_signed   = (mop == 3'd1);
  assign div_signed = ~mop[0];
  assign div_zero   = (opr_b_i == '0);
  assign div_ovf    = div_signed & (opr_a_i == MIN_NEG) & (opr_b_i == '1);
  assign a_ext      = a_signed ? {{XLEN{opr_a_i[XLEN-1]}}, opr_a_i} : {{XLEN{1'b0}}, opr_a_i};
  assign a_mag      = (div_signed & opr_a_i[XLEN-1]) ? -opr_a_i : opr_a_i;
  assign b_mag      = (div_signed & opr_b_i[XLEN-1]) ? -opr_b_i : opr_b_i;

`ifdef RISCV_EXEC_FASTMUL_EN
  logic [2*XLEN-1:0] b_ext, fast_prod;
  assign b_ext     = b_signed ? {{XLEN{opr_b_i[XLEN-1]}}, opr_b_i} : {{XLEN{1'b0}}, opr_b_i};
  assign fast_prod = a_ext * b_ext;
`endif

  // A signed multiplier's MSB carries negative weight, so its partial product is subtracted.
  assign pp      = mplier_reg[0] ? mcand_reg : '0;
  assign mul_sum = ((cnt_reg == CNT_LAST) & msb_neg_reg) ? acc_reg - pp : acc_reg + pp;

  assign r_shift  = {rem_reg, quo_reg[XLEN-1]};
  assign ge       = (r_shift >= {1'b0, dvsr_reg});
  assign diff     = r_shift[XLEN-1:0] - dvsr_reg;
  assign rem_step = ge ? diff : r_shift[XLEN-1:0];
  assign quo_step = {quo_reg[XLEN-2:0], ge};
  assign q_fix    = neg_q_reg ? -quo_step : quo_step;
  assign r_fix    = neg_r_reg ? -rem_step : rem_step;

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    cnt_next     = cnt_reg;
    res_next     = res_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    msb_neg_next = msb_neg_reg;
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    dvsr_next    = dvsr_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (state_reg == DONE && ready_i) state_next = IDLE;
        if (accept) begin
          op_next  = mop;
          cnt_next = '0;
          if (!is_m) begin
            res_next   = alu_f(opr_a_i, opr_b_i, op_sel_i[3:0]);
            state_next = DONE;
          end else if (!is_div) begin
`ifdef RISCV_EXEC_FASTMUL_EN
            res_next   = (mop == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_next = DONE;
`else
            acc_next     = '0;
            mcand_next   = a_ext;
            mplier_next  = opr_b_i;
            msb_neg_next = b_signed;
            state_next   = MUL_BUSY;
`endif
          end else if (div_zero) begin
            res_next   = mop[1] ? opr_a_i : '1;
            state_next = DONE;
          end else if (div_ovf) begin
            res_next   = mop[1] ? '0 : opr_a_i;
            state_next = DONE;
          end else begin
            rem_next   = '0;
            quo_next   = a_mag;
            dvsr_next  = b_mag;
            neg_q_next = div_signed & (opr_a_i[XLEN-1] ^ opr_b_i[XLEN-1]);
            neg_r_next = div_signed & opr_a_i[XLEN-1];
            state_next = DIV_BUSY;
          end
        end
      end
      MUL_BUSY: begin
        acc_next    = mul_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) begin
          res_next   = (op_reg == 3'd0) ? mul_sum[XLEN-1:0] : mul_sum[2*XLEN-1:XLEN];
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      DIV_BUSY: begin
        rem_next = rem_step;
        quo_next = quo_step;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) begin
          res_next   = op_reg[1] ? r_fix : q_fix;
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (kill_i) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      cnt_reg     <= '0;
      res_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      msb_neg_reg <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvsr_reg    <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      cnt_reg     <= cnt_next;
      res_reg     <= res_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      msb_neg_reg <= msb_neg_next;
      rem_reg     <= rem_next;
      quo_reg     <= quo_next;
      dvsr_reg    <= dvsr_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
    end
  end
endmodule

// File: tb/tb_riscv_execute_mc.sv
// Scoreboard bench for riscv_execute_mc (XLEN=32): ALU, MUL*, DIV*, special cases, backpressure, kill, reset.
module tb_riscv_execute_mc;
  logic        clk = 1'b0;
  logic        reset_n, valid_i, ready_o, kill_i, valid_o, ready_i;
  logic [31:0] opr_a_i, opr_b_i, ex_res_o;
  logic [4:0]  op_sel_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

`ifdef RISCV_EXEC_FASTMUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  riscv_execute_mc #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .opr_a_i(opr_a_i), .opr_b_i(opr_b_i), .op_sel_i(op_sel_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .ex_res_o(ex_res_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until the edge that accepts it; returns 1 ns after that edge.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output bit to);
    int w;
    to = 1'b0;
    w = 0;
    valid_i = 1'b1; op_sel_i = op; opr_a_i = a; opr_b_i = b;
    while (ready_o !== 1'b1 && w < 100) begin step(); w++; end
    if (w >= 100) to = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic wait_result(output logic [31:0] got, output int lat, output bit to);
    lat = 1;
    while (valid_o !== 1'b1 && lat < 200) begin step(); lat++; end
    to = (valid_o !== 1'b1);
    got = ex_res_o;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    op_sel_i = '0; opr_a_i = '0; opr_b_i = '0;
    repeat (3) step();
    reset_n = 1'b1;
    n_cmp++;
    if (valid_o !== 1'b0 || ex_res_o !== 32'h0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset: valid_o=%b ex_res_o=%h ready_o=%b, want 0 00000000 1", valid_o, ex_res_o, ready_o);
    end
    $display("reset: valid_o=%b ex_res_o=%h ready_o=%b", valid_o, ex_res_o, ready_o);
  endtask

  task automatic test_alu();
    logic [4:0]  ops[16] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                            5'd7, 5'd8, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
    logic [31:0] as[16]  = '{32'd5, 32'h800000F0, 32'h800000F0, 32'h800000F0, 32'h800000F0,
                            32'h800000F0, 32'h800000F0, 32'h800000F0, 32'h800000F0, 32'h800000F0,
                            32'd3, 32'h800000F0, 32'h800000F0, 32'h800000F0, 32'h800000F0, 32'h800000F0};
    logic [31:0] bs[16]  = '{32'd7, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4,
                            32'd4, 32'd4, 32'd3, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4};
    logic [31:0] ex[16]  = '{32'h0000000C, 32'h800000F4, 32'h800000EC, 32'h00000F00, 32'h0800000F,
                            32'hF800000F, 32'h800000F4, 32'h00000000, 32'h800000F4, 32'h0,
                            32'h1, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0};
    logic [31:0] got, e;
    int lat;
    bit t1, t2;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(ex[i]);
      send(ops[i], as[i], bs[i], t1);
      wait_result(got, lat, t2);
      e = exp_q.pop_front();
      n_cmp++;
      if (t1 || t2 || got !== e || lat != 1) begin
        n_err++;
        $display("FAIL alu[%0d] op=%0d: got=%h lat=%0d timeout=%b, want %h lat=1", i, ops[i], got, lat, t1 | t2, e);
      end
      $display("alu op=%0d a=%h b=%h -> %h lat=%0d", ops[i], as[i], bs[i], got, lat);
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, e;
    int lat;
    bit t1, t2;
    exp_q.push_back(32'h0000000C);
    send(5'd0, 32'd5, 32'd7, t1);
    wait_result(got, lat, t2);
    e = exp_q.pop_front();
    n_cmp++;
    if (t1 || t2 || got !== e || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got=%h ready_o=%b, want %h ready_o=1", got, ready_o, e);
    end
    exp_q.push_back(32'd6);
    valid_i = 1'b1; op_sel_i = 5'd1; opr_a_i = 32'd9; opr_b_i = 32'd3;
    step();
    valid_i = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (valid_o !== 1'b1 || ex_res_o !== e) begin
      n_err++;
      $display("FAIL b2b_second: valid_o=%b ex_res_o=%h, want 1 %h", valid_o, ex_res_o, e);
    end
    $display("b2b: first=%h second=%h", got, ex_res_o);
    step();
  endtask

  task automatic test_mul();
    logic [4:0]  ops[5] = '{5'h11, 5'h13, 5'h10, 5'h12, 5'h10};
    logic [31:0] as[5]  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [31:0] bs[5]  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'd2, 32'd5};
    logic [31:0] ex[5]  = '{32'h40000000, 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF1};
    logic [31:0] got, e;
    int lat;
    bit t1, t2;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      send(ops[i], as[i], bs[i], t1);
      wait_result(got, lat, t2);
      e = exp_q.pop_front();
      n_cmp++;
      if (t1 || t2 || got !== e || lat != MUL_LAT) begin
        n_err++;
        $display("FAIL mul[%0d] op=%h: got=%h lat=%0d, want %h lat=%0d", i, ops[i], got, lat, e, MUL_LAT);
      end
      $display("mul op=%h a=%h b=%h -> %h lat=%0d", ops[i], as[i], bs[i], got, lat);
      step();
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops[5] = '{5'h14, 5'h16, 5'h15, 5'h17, 5'h16};
    logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7};
    logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE};
    logic [31:0] ex[5]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'd1};
    logic [31:0] got, e;
    int lat;
    bit t1, t2;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      send(ops[i], as[i], bs[i], t1);
      wait_result(got, lat, t2);
      e = exp_q.pop_front();
      n_cmp++;
      if (t1 || t2 || got !== e || lat != 33) begin
        n_err++;
        $display("FAIL div[%0d] op=%h: got=%h lat=%0d, want %h lat=33", i, ops[i], got, lat, e);
      end
      $display("div op=%h a=%h b=%h -> %h lat=%0d", ops[i], as[i], bs[i], got, lat);
      step();
    end
  endtask

  task automatic test_div_special();
    logic [4:0]  ops[5] = '{5'h15, 5'h17, 5'h14, 5'h16, 5'h14};
    logic [31:0] as[5]  = '{32'd100, 32'd100, 32'h80000000, 32'h80000000, 32'd5};
    logic [31:0] bs[5]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] ex[5]  = '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0, 32'hFFFFFFFF};
    logic [31:0] got, e;
    int lat;
    bit t1, t2;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      send(ops[i], as[i], bs[i], t1);
      wait_result(got, lat, t2);
      e = exp_q.pop_front();
      n_cmp++;
      if (t1 || t2 || got !== e || lat != 1) begin
        n_err++;
        $display("FAIL divspec[%0d] op=%h: got=%h lat=%0d, want %h lat=1", i, ops[i], got, lat, e);
      end
      $display("divspec op=%h a=%h b=%h -> %h lat=%0d", ops[i], as[i], bs[i], got, lat);
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    bit t1;
    ready_i = 1'b0;
    exp_q.push_back(32'd2);
    send(5'd0, 32'd1, 32'd1, t1);
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (t1 || valid_o !== 1'b1 || ex_res_o !== e || ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid_o=%b ex_res_o=%h ready_o=%b, want 1 %h 0", c, valid_o, ex_res_o, ready_o, e);
      end
      step();
    end
    ready_i = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready: ready_o=%b, want 1", ready_o);
    end
    step();
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_retire: valid_o=%b, want 0", valid_o);
    end
    $display("backpressure: held %h, retired", e);
  endtask

  task automatic test_kill();
    bit t1, seen;
    send(5'h15, 32'd1000, 32'd3, t1);
    repeat (9) step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    n_cmp++;
    if (t1 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL kill_idle: valid_o=%b ready_o=%b, want 0 1", valid_o, ready_o);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o === 1'b1) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL kill_noresult: valid_o seen=%b, want 0", seen);
    end
    valid_i = 1'b1; op_sel_i = 5'd0; opr_a_i = 32'd1; opr_b_i = 32'd2; kill_i = 1'b1;
    step();
    valid_i = 1'b0; kill_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL kill_drop_accept: valid_o=%b, want 0", valid_o);
    end
    $display("kill: in-flight DIVU and same-cycle accept dropped");
  endtask

  task automatic test_reset_mid_op();
    bit t1, seen;
    send(5'h10, 32'd7, 32'd6, t1);
    repeat (5) step();
    reset_n = 1'b0;
    step();
    n_cmp++;
    if (t1 || valid_o !== 1'b0 || ex_res_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid: valid_o=%b ex_res_o=%h, want 0 00000000", valid_o, ex_res_o);
    end
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o === 1'b1) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0 || ready_o !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_after: valid seen=%b ready_o=%b queue=%0d, want 0 1 0", seen, ready_o, exp_q.size());
    end
    $display("reset_mid: op discarded");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_kill();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
